// File: rtl/ex_pkg.sv
// Shared definitions for the execute-stage control slice: FSM state
// encodings and the layout of the packed forwarding-source vectors.
package ex_pkg;

  // FSM state encodings
  localparam int         ST_W       = 2;
  localparam logic [1:0] ST_RUN     = 2'd0;  // accepting instructions
  localparam logic [1:0] ST_MC_WAIT = 2'd1;  // multi-cycle unit computing
  localparam logic [1:0] ST_MC_HOLD = 2'd2;  // mc result parked, EX/MEM busy

  // Forwarding-source slots in the packed source vectors handed to
  // ex_fwd_select. Lower index = higher priority. The stage's own EX/MEM
  // register is always the youngest writer, so it sits at slot 0 and the
  // external sources follow in their own priority order.
  localparam int FWD_OWN_IDX  = 0;
  localparam int FWD_EXT_BASE = 1;

  // Number of forwarding slots (own register + external sources).
  function automatic int fwd_nsrc(input int nfwd);
    return nfwd + 1;
  endfunction

endpackage

// File: rtl/ex_fwd_select.sv
// Priority forwarding for one operand: finds the highest-priority live
// writer of the requested register, muxes its data in place of the
// regfile value, and flags a hazard if that writer's data is not ready.
module ex_fwd_select
  import ex_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int NSRC    = 3
) (
  input  logic [RADDR_W-1:0]      label_i,
  input  logic [XLEN-1:0]         rf_value_i,
  input  logic [NSRC-1:0]         src_valid_i,
  input  logic [NSRC*RADDR_W-1:0] src_rd_i,
  input  logic [NSRC*XLEN-1:0]    src_data_i,
  input  logic [NSRC-1:0]         src_rdy_i,
  output logic [XLEN-1:0]         value_o,
  output logic                    hazard_o
);

  logic [NSRC-1:0] w_match;

  // x0 is hardwired zero, so a writer targeting it never forwards.
  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_match
      assign w_match[gi] = src_valid_i[gi]
                        && (src_rd_i[gi*RADDR_W +: RADDR_W] == label_i)
                        && (label_i != '0);
    end
  endgenerate

  // Walk from lowest to highest priority so the last hit (lowest index) wins.
  always_comb begin
    value_o  = rf_value_i;
    hazard_o = 1'b0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      if (w_match[k]) begin
        value_o  = src_data_i[k*XLEN +: XLEN];
        hazard_o = !src_rdy_i[k];
      end
    end
  end

endmodule

// File: rtl/ex_pipe_ctrl.sv
// Execute-stage control and EX/MEM pipeline register. Resolves both source
// operands through priority forwarding, issues single-cycle ops directly or
// hands multi-cycle ops to an external unit, and presents the result to MEM
// through a valid/ready handshake. A flush kills only the instruction in EX;
// the older instruction already in EX/MEM is never touched.
module ex_pipe_ctrl
  import ex_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int NFWD    = 2,
  parameter int CTRL_W  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  // ID/EX side
  input  logic                    id_valid_i,
  output logic                    id_ready_o,
  input  logic [RADDR_W-1:0]      id_rs1_label_i,
  input  logic [RADDR_W-1:0]      id_rs2_label_i,
  input  logic [XLEN-1:0]         id_rs1_value_i,
  input  logic [XLEN-1:0]         id_rs2_value_i,
  input  logic [RADDR_W-1:0]      id_rd_i,
  input  logic                    id_wb_en_i,
  input  logic                    id_mc_i,
  input  logic [CTRL_W-1:0]       id_ctrl_i,
  // external forwarding sources, index 0 = youngest
  input  logic [NFWD-1:0]         fwd_valid_i,
  input  logic [NFWD*RADDR_W-1:0] fwd_rd_i,
  input  logic [NFWD*XLEN-1:0]    fwd_data_i,
  input  logic [NFWD-1:0]         fwd_rdy_i,
  // execution units
  output logic [XLEN-1:0]         op1_o,
  output logic [XLEN-1:0]         op2_o,
  input  logic [XLEN-1:0]         comb_res_i,
  output logic                    mc_start_o,
  output logic                    mc_kill_o,
  input  logic                    mc_done_i,
  input  logic [XLEN-1:0]         mc_res_i,
  // redirect
  input  logic                    flush_i,
  // EX/MEM side
  output logic                    mem_valid_o,
  input  logic                    mem_ready_i,
  output logic [RADDR_W-1:0]      mem_rd_o,
  output logic                    mem_wb_en_o,
  output logic [XLEN-1:0]         mem_res_o,
  output logic [XLEN-1:0]         mem_rs2_o,
  output logic [CTRL_W-1:0]       mem_ctrl_o
);

  localparam int NSRC = fwd_nsrc(NFWD);

  // FSM and multi-cycle operand latches
  logic [ST_W-1:0]    r_state;
  logic [XLEN-1:0]    r_op1;
  logic [XLEN-1:0]    r_op2;
  logic [RADDR_W-1:0] r_op_rd;
  logic               r_op_wb_en;
  logic [CTRL_W-1:0]  r_op_ctrl;
  logic [XLEN-1:0]    r_hold;

  // EX/MEM register
  logic               r_mem_valid;
  logic [RADDR_W-1:0] r_mem_rd;
  logic               r_mem_wb_en;
  logic [XLEN-1:0]    r_mem_res;
  logic [XLEN-1:0]    r_mem_rs2;
  logic [CTRL_W-1:0]  r_mem_ctrl;

  // forwarding
  logic [NSRC-1:0]         w_src_valid;
  logic [NSRC*RADDR_W-1:0] w_src_rd;
  logic [NSRC*XLEN-1:0]    w_src_data;
  logic [NSRC-1:0]         w_src_rdy;
  logic [XLEN-1:0]         w_rs1_fwd;
  logic [XLEN-1:0]         w_rs2_fwd;
  logic                    w_rs1_haz;
  logic                    w_rs2_haz;

  // handshake / control
  logic w_in_run;
  logic w_in_wait;
  logic w_in_hold;
  logic w_slot_free;
  logic w_accept;
  logic w_load_comb;
  logic w_load_mc;
  logic w_load_hold;

  // EX/MEM next values
  logic [RADDR_W-1:0] w_mem_rd_next;
  logic               w_mem_wb_en_next;
  logic [XLEN-1:0]    w_mem_res_next;
  logic [XLEN-1:0]    w_mem_rs2_next;
  logic [CTRL_W-1:0]  w_mem_ctrl_next;

  // Own EX/MEM register occupies the top-priority slot; its data is always
  // available, so it can never raise a hazard.
  assign w_src_valid[FWD_OWN_IDX]                    = r_mem_valid && r_mem_wb_en;
  assign w_src_rd[FWD_OWN_IDX*RADDR_W +: RADDR_W]    = r_mem_rd;
  assign w_src_data[FWD_OWN_IDX*XLEN +: XLEN]        = r_mem_res;
  assign w_src_rdy[FWD_OWN_IDX]                      = 1'b1;

  assign w_src_valid[FWD_EXT_BASE +: NFWD]                 = fwd_valid_i;
  assign w_src_rd[FWD_EXT_BASE*RADDR_W +: NFWD*RADDR_W]    = fwd_rd_i;
  assign w_src_data[FWD_EXT_BASE*XLEN +: NFWD*XLEN]        = fwd_data_i;
  assign w_src_rdy[FWD_EXT_BASE +: NFWD]                   = fwd_rdy_i;

  ex_fwd_select #(
    .XLEN    (XLEN),
    .RADDR_W (RADDR_W),
    .NSRC    (NSRC)
  ) u_fwd_rs1 (
    .label_i     (id_rs1_label_i),
    .rf_value_i  (id_rs1_value_i),
    .src_valid_i (w_src_valid),
    .src_rd_i    (w_src_rd),
    .src_data_i  (w_src_data),
    .src_rdy_i   (w_src_rdy),
    .value_o     (w_rs1_fwd),
    .hazard_o    (w_rs1_haz)
  );

  ex_fwd_select #(
    .XLEN    (XLEN),
    .RADDR_W (RADDR_W),
    .NSRC    (NSRC)
  ) u_fwd_rs2 (
    .label_i     (id_rs2_label_i),
    .rf_value_i  (id_rs2_value_i),
    .src_valid_i (w_src_valid),
    .src_rd_i    (w_src_rd),
    .src_data_i  (w_src_data),
    .src_rdy_i   (w_src_rdy),
    .value_o     (w_rs2_fwd),
    .hazard_o    (w_rs2_haz)
  );

  assign w_in_run    = (r_state == ST_RUN);
  assign w_in_wait   = (r_state == ST_MC_WAIT);
  assign w_in_hold   = (r_state == ST_MC_HOLD);
  assign w_slot_free = !r_mem_valid || mem_ready_i;

  // A hazard on either operand stalls the whole instruction, even if the
  // op ignores that operand; ID does not tell us which operands are live.
  assign id_ready_o = w_in_run && w_slot_free && !w_rs1_haz && !w_rs2_haz && !flush_i;
  assign w_accept   = id_valid_i && id_ready_o;
  assign mc_start_o = w_accept && id_mc_i;
  assign mc_kill_o  = w_in_wait && flush_i;

  // While the multi-cycle unit owns the op, hold its operands steady even
  // though the ID/EX register and forwarding sources keep moving.
  assign op1_o = w_in_run ? w_rs1_fwd : r_op1;
  assign op2_o = w_in_run ? w_rs2_fwd : r_op2;

  // Flush always wins over a same-cycle mc completion.
  assign w_load_comb = w_accept && !id_mc_i;
  assign w_load_mc   = w_in_wait && !flush_i && mc_done_i && w_slot_free;
  assign w_load_hold = w_in_hold && !flush_i && w_slot_free;

  // Select what the EX/MEM register captures: a fresh single-cycle result,
  // or the completed multi-cycle result with its latched sideband.
  always_comb begin
    w_mem_rd_next    = r_op_rd;
    w_mem_wb_en_next = r_op_wb_en;
    w_mem_res_next   = w_load_mc ? mc_res_i : r_hold;
    w_mem_rs2_next   = r_op2;
    w_mem_ctrl_next  = r_op_ctrl;
    if (w_load_comb) begin
      w_mem_rd_next    = id_rd_i;
      w_mem_wb_en_next = id_wb_en_i;
      w_mem_res_next   = comb_res_i;
      w_mem_rs2_next   = w_rs2_fwd;
      w_mem_ctrl_next  = id_ctrl_i;
    end
  end

  // FSM sequencing the multi-cycle unit; latches the op on issue and parks
  // an early result if EX/MEM cannot take it yet.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_RUN;
      r_op1      <= '0;
      r_op2      <= '0;
      r_op_rd    <= '0;
      r_op_wb_en <= 1'b0;
      r_op_ctrl  <= '0;
      r_hold     <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_accept && id_mc_i) begin
            r_op1      <= w_rs1_fwd;
            r_op2      <= w_rs2_fwd;
            r_op_rd    <= id_rd_i;
            r_op_wb_en <= id_wb_en_i;
            r_op_ctrl  <= id_ctrl_i;
            r_state    <= ST_MC_WAIT;
          end
        end
        ST_MC_WAIT: begin
          if (flush_i) begin
            r_state <= ST_RUN;
          end else if (mc_done_i) begin
            if (w_slot_free) begin
              r_state <= ST_RUN;
            end else begin
              r_hold  <= mc_res_i;
              r_state <= ST_MC_HOLD;
            end
          end
        end
        ST_MC_HOLD: begin
          if (flush_i || w_slot_free) begin
            r_state <= ST_RUN;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  // EX/MEM register: loads on a completed op, drains when MEM consumes,
  // and otherwise holds everything stable for the downstream stage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mem_valid <= 1'b0;
      r_mem_rd    <= '0;
      r_mem_wb_en <= 1'b0;
      r_mem_res   <= '0;
      r_mem_rs2   <= '0;
      r_mem_ctrl  <= '0;
    end else if (w_load_comb || w_load_mc || w_load_hold) begin
      r_mem_valid <= 1'b1;
      r_mem_rd    <= w_mem_rd_next;
      r_mem_wb_en <= w_mem_wb_en_next;
      r_mem_res   <= w_mem_res_next;
      r_mem_rs2   <= w_mem_rs2_next;
      r_mem_ctrl  <= w_mem_ctrl_next;
    end else if (mem_ready_i) begin
      r_mem_valid <= 1'b0;
    end
  end

  assign mem_valid_o = r_mem_valid;
  assign mem_rd_o    = r_mem_rd;
  assign mem_wb_en_o = r_mem_wb_en;
  assign mem_res_o   = r_mem_res;
  assign mem_rs2_o   = r_mem_rs2;
  assign mem_ctrl_o  = r_mem_ctrl;

endmodule

// File: tb/tb_ex_pipe_ctrl.sv
// Self-checking bench for ex_pipe_ctrl: directed scenarios with literal
// expectations followed by randomized traffic, all checked every cycle
// against a transaction-level model of the EX stage.
module tb_ex_pipe_ctrl;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;
  localparam int NFWD    = 2;
  localparam int CTRL_W  = 16;

  logic                    clk_i = 1'b0;
  logic                    rst_ni;
  logic                    id_valid_i;
  logic                    id_ready_o;
  logic [RADDR_W-1:0]      id_rs1_label_i, id_rs2_label_i;
  logic [XLEN-1:0]         id_rs1_value_i, id_rs2_value_i;
  logic [RADDR_W-1:0]      id_rd_i;
  logic                    id_wb_en_i, id_mc_i;
  logic [CTRL_W-1:0]       id_ctrl_i;
  logic [NFWD-1:0]         fwd_valid_i, fwd_rdy_i;
  logic [NFWD*RADDR_W-1:0] fwd_rd_i;
  logic [NFWD*XLEN-1:0]    fwd_data_i;
  logic [XLEN-1:0]         op1_o, op2_o, comb_res_i, mc_res_i;
  logic                    mc_start_o, mc_kill_o, mc_done_i, flush_i;
  logic                    mem_valid_o, mem_ready_i, mem_wb_en_o;
  logic [RADDR_W-1:0]      mem_rd_o;
  logic [XLEN-1:0]         mem_res_o, mem_rs2_o;
  logic [CTRL_W-1:0]       mem_ctrl_o;

  always #5 clk_i = ~clk_i;

  ex_pipe_ctrl #(.XLEN(XLEN), .RADDR_W(RADDR_W), .NFWD(NFWD), .CTRL_W(CTRL_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
    .id_rs1_label_i(id_rs1_label_i), .id_rs2_label_i(id_rs2_label_i),
    .id_rs1_value_i(id_rs1_value_i), .id_rs2_value_i(id_rs2_value_i),
    .id_rd_i(id_rd_i), .id_wb_en_i(id_wb_en_i), .id_mc_i(id_mc_i), .id_ctrl_i(id_ctrl_i),
    .fwd_valid_i(fwd_valid_i), .fwd_rd_i(fwd_rd_i), .fwd_data_i(fwd_data_i), .fwd_rdy_i(fwd_rdy_i),
    .op1_o(op1_o), .op2_o(op2_o), .comb_res_i(comb_res_i),
    .mc_start_o(mc_start_o), .mc_kill_o(mc_kill_o), .mc_done_i(mc_done_i), .mc_res_i(mc_res_i),
    .flush_i(flush_i),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_rd_o(mem_rd_o),
    .mem_wb_en_o(mem_wb_en_o), .mem_res_o(mem_res_o), .mem_rs2_o(mem_rs2_o), .mem_ctrl_o(mem_ctrl_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit        valid;
    bit [4:0]  rd;
    bit        wb_en;
    bit [31:0] res;
    bit [31:0] rs2;
    bit [15:0] ctrl;
  } slot_t;

  typedef struct {
    bit [31:0] op1;
    bit [31:0] op2;
    bit [4:0]  rd;
    bit        wb_en;
    bit [15:0] ctrl;
  } mcop_t;

  slot_t     m_slot, n_slot;     // what MEM currently sees
  mcop_t     m_pend[$], n_pend[$]; // op handed to the multi-cycle unit (0 or 1)
  bit        m_have, n_have;     // unit already delivered, result parked
  bit [31:0] m_held, n_held;

  // Youngest live writer of a nonzero register supplies the value.
  function automatic void resolve(input bit [4:0] lbl, input bit [31:0] rf,
                                  output bit [31:0] v, output bit hz);
    v  = rf;
    hz = 1'b0;
    if (lbl == 5'd0) return;
    if (m_slot.valid && m_slot.wb_en && m_slot.rd == lbl) begin
      v = m_slot.res;
      return;
    end
    for (int k = 0; k < NFWD; k++) begin
      if (fwd_valid_i[k] && fwd_rd_i[k*RADDR_W +: RADDR_W] == lbl) begin
        v  = fwd_data_i[k*XLEN +: XLEN];
        hz = !fwd_rdy_i[k];
        return;
      end
    end
  endfunction

  function automatic slot_t retire(input mcop_t p, input bit [31:0] r);
    slot_t s;
    s.valid = 1'b1;
    s.rd    = p.rd;
    s.wb_en = p.wb_en;
    s.res   = r;
    s.rs2   = p.op2;
    s.ctrl  = p.ctrl;
    return s;
  endfunction

  function automatic void model_reset();
    m_slot = '{default: 0};
    m_pend.delete();
    m_have = 1'b0;
    m_held = '0;
  endfunction

  // Compare every DUT output with the model, then work out the model's
  // state after the coming clock edge.
  task automatic eval_cycle();
    bit [31:0] e1, e2;
    bit h1, h2, busy, waiting, sfree, ready;
    #1;
    if (!rst_ni) model_reset();
    busy    = (m_pend.size() != 0);
    waiting = busy && !m_have;
    sfree   = !m_slot.valid || mem_ready_i;
    resolve(id_rs1_label_i, id_rs1_value_i, e1, h1);
    resolve(id_rs2_label_i, id_rs2_value_i, e2, h2);
    ready = !busy && sfree && !h1 && !h2 && !flush_i;

    chk("mem_valid", {31'd0, mem_valid_o}, {31'd0, m_slot.valid});
    chk("mem_rd",    {27'd0, mem_rd_o},    {27'd0, m_slot.rd});
    chk("mem_wb_en", {31'd0, mem_wb_en_o}, {31'd0, m_slot.wb_en});
    chk("mem_res",   mem_res_o,            m_slot.res);
    chk("mem_rs2",   mem_rs2_o,            m_slot.rs2);
    chk("mem_ctrl",  {16'd0, mem_ctrl_o},  {16'd0, m_slot.ctrl});
    chk("id_ready",  {31'd0, id_ready_o},  {31'd0, ready});
    chk("mc_start",  {31'd0, mc_start_o},  {31'd0, ready && id_valid_i && id_mc_i});
    chk("mc_kill",   {31'd0, mc_kill_o},   {31'd0, waiting && flush_i});
    if (busy) begin
      chk("op1_held", op1_o, m_pend[0].op1);
      chk("op2_held", op2_o, m_pend[0].op2);
    end else begin
      if (!h1) chk("op1_fwd", op1_o, e1);
      if (!h2) chk("op2_fwd", op2_o, e2);
    end

    n_slot = m_slot;
    n_pend = m_pend;
    n_have = m_have;
    n_held = m_held;
    if (rst_ni) begin
      if (mem_ready_i) n_slot.valid = 1'b0;
      if (!busy) begin
        if (ready && id_valid_i) begin
          if (id_mc_i) begin
            n_pend.push_back('{e1, e2, id_rd_i, id_wb_en_i, id_ctrl_i});
            n_have = 1'b0;
          end else begin
            n_slot = '{1'b1, id_rd_i, id_wb_en_i, comb_res_i, e2, id_ctrl_i};
          end
        end
      end else if (flush_i) begin
        n_pend.delete();
        n_have = 1'b0;
      end else if (!m_have) begin
        if (mc_done_i) begin
          if (sfree) begin
            n_slot = retire(m_pend[0], mc_res_i);
            n_pend.delete();
          end else begin
            n_have = 1'b1;
            n_held = mc_res_i;
          end
        end
      end else if (sfree) begin
        n_slot = retire(m_pend[0], m_held);
        n_pend.delete();
        n_have = 1'b0;
      end
    end
  endtask

  task automatic adv();
    @(negedge clk_i);
    m_slot = n_slot;
    m_pend = n_pend;
    m_have = n_have;
    m_held = n_held;
  endtask

  task automatic quiet();
    id_valid_i = 0; id_rs1_label_i = '0; id_rs2_label_i = '0;
    id_rs1_value_i = '0; id_rs2_value_i = '0; id_rd_i = '0;
    id_wb_en_i = 0; id_mc_i = 0; id_ctrl_i = '0;
    fwd_valid_i = '0; fwd_rd_i = '0; fwd_data_i = '0; fwd_rdy_i = '1;
    comb_res_i = '0; mc_done_i = 0; mc_res_i = '0; flush_i = 0; mem_ready_i = 0;
  endtask

  task automatic rand_inputs();
    id_valid_i     = ($urandom_range(0, 3) != 0);
    id_rs1_label_i = 5'($urandom_range(0, 3));
    id_rs2_label_i = 5'($urandom_range(0, 3));
    id_rs1_value_i = $urandom();
    id_rs2_value_i = $urandom();
    id_rd_i        = 5'($urandom_range(0, 3));
    id_wb_en_i     = ($urandom_range(0, 3) != 0);
    id_mc_i        = ($urandom_range(0, 3) == 0);
    id_ctrl_i      = 16'($urandom());
    for (int k = 0; k < NFWD; k++) begin
      fwd_valid_i[k]                  = ($urandom_range(0, 1) == 1);
      fwd_rd_i[k*RADDR_W +: RADDR_W]  = 5'($urandom_range(0, 3));
      fwd_data_i[k*XLEN +: XLEN]      = $urandom();
      fwd_rdy_i[k]                    = ($urandom_range(0, 4) != 0);
    end
    comb_res_i  = $urandom();
    mc_done_i   = ($urandom_range(0, 4) == 0);
    mc_res_i    = $urandom();
    flush_i     = ($urandom_range(0, 9) == 0);
    mem_ready_i = ($urandom_range(0, 2) != 0);
    rst_ni      = ($urandom_range(0, 499) != 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    quiet();
    rst_ni = 0;
    model_reset();
    @(negedge clk_i);

    // reset state
    eval_cycle();
    chk("rst_mem_valid", {31'd0, mem_valid_o}, 32'd0);
    chk("rst_mem_res", mem_res_o, 32'd0);
    adv();
    rst_ni = 1;

    // own EX/MEM register beats fwd source 0
    id_valid_i = 1; id_rd_i = 5'd5; id_wb_en_i = 1; comb_res_i = 32'h11;
    eval_cycle();
    chk("own_issue_ready", {31'd0, id_ready_o}, 32'd1);
    adv();
    quiet();
    id_rs1_label_i = 5'd5; id_rs1_value_i = 32'h99;
    fwd_valid_i = 2'b01; fwd_rd_i = {5'd0, 5'd5}; fwd_data_i = {32'h0, 32'h22};
    eval_cycle();
    chk("own_wins", op1_o, 32'h11);
    adv();

    // pending load on source 0 stalls until its data arrives
    quiet();
    id_valid_i = 1; id_rs2_label_i = 5'd7; id_rd_i = 5'd0; id_wb_en_i = 1;
    comb_res_i = 32'hFF; mem_ready_i = 1;
    fwd_valid_i = 2'b01; fwd_rd_i = {5'd0, 5'd7}; fwd_data_i = {32'h0, 32'h77}; fwd_rdy_i = 2'b10;
    eval_cycle();
    chk("load_stall", {31'd0, id_ready_o}, 32'd0);
    adv();
    eval_cycle();
    chk("load_stall2", {31'd0, id_ready_o}, 32'd0);
    adv();
    fwd_rdy_i = 2'b11;
    eval_cycle();
    chk("load_release", {31'd0, id_ready_o}, 32'd1);
    chk("load_op2", op2_o, 32'h77);
    adv();

    // x0 never forwards, even with every source (incl. EX/MEM) writing x0
    quiet();
    mem_ready_i = 1; id_rs1_value_i = 32'h1234;
    fwd_valid_i = 2'b11; fwd_rd_i = '0; fwd_data_i = {32'hFF, 32'hFF};
    eval_cycle();
    chk("x0_regfile", op1_o, 32'h1234);
    adv();

    // multi-cycle op: start pulse, stable operands, result after done
    quiet();
    id_valid_i = 1; id_mc_i = 1; id_rs1_label_i = 5'd3; id_rs1_value_i = 32'hA0;
    id_rs2_label_i = 5'd4; id_rs2_value_i = 32'hB0; id_rd_i = 5'd9; id_wb_en_i = 1;
    id_ctrl_i = 16'hBEEF;
    eval_cycle();
    chk("mc_start", {31'd0, mc_start_o}, 32'd1);
    adv();
    id_rs1_value_i = 32'h5555;
    for (int c = 0; c < 3; c++) begin
      eval_cycle();
      chk("mc_wait_ready", {31'd0, id_ready_o}, 32'd0);
      chk("mc_op1_stable", op1_o, 32'hA0);
      adv();
    end
    mc_done_i = 1; mc_res_i = 32'hCAFE;
    eval_cycle();
    adv();
    quiet();
    eval_cycle();
    chk("mc_res", mem_res_o, 32'hCAFE);
    chk("mc_rd", {27'd0, mem_rd_o}, 32'd9);
    chk("mc_rs2", mem_rs2_o, 32'hB0);
    chk("mc_ctrl", {16'd0, mem_ctrl_o}, 32'hBEEF);
    chk("mc_slot_full", {31'd0, id_ready_o}, 32'd0);
    adv();

    // flush beats mc_done: kill pulse, result dropped, back to RUN
    id_valid_i = 1; id_mc_i = 1; mem_ready_i = 1;
    eval_cycle();
    adv();
    quiet();
    eval_cycle();
    adv();
    flush_i = 1; mc_done_i = 1; mc_res_i = 32'hDEAD;
    eval_cycle();
    chk("flush_kill", {31'd0, mc_kill_o}, 32'd1);
    adv();
    quiet();
    eval_cycle();
    chk("flush_mem_valid", {31'd0, mem_valid_o}, 32'd0);
    chk("flush_mem_res", mem_res_o, 32'hCAFE);
    chk("flush_run", {31'd0, id_ready_o}, 32'd1);
    adv();

    // asynchronous reset in the middle of MC_WAIT
    id_valid_i = 1; id_mc_i = 1; mem_ready_i = 1;
    eval_cycle();
    adv();
    quiet();
    rst_ni = 0;
    eval_cycle();
    chk("arst_mem_res", mem_res_o, 32'd0);
    chk("arst_mem_ctrl", {16'd0, mem_ctrl_o}, 32'd0);
    chk("arst_mem_valid", {31'd0, mem_valid_o}, 32'd0);
    adv();
    rst_ni = 1;
    eval_cycle();
    chk("arst_run", {31'd0, id_ready_o}, 32'd1);
    adv();

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      rand_inputs();
      eval_cycle();
      adv();
    end

    quiet();
    rst_ni = 1;
    eval_cycle();
    adv();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
